// File: rtl/shot_clock_timer.sv
// Billiard shot clock: BCD seconds countdown with pause, warning window and
// a one-cycle time_up pulse on reaching 00.
module shot_clock_timer #(
    parameter logic [3:0] START_TENS = 4'd3,
    parameter logic [3:0] START_ONES = 4'd0,
    parameter int         WARN_SEC   = 5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       one_sec,
    input  logic       start_shot,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       warning,
    output logic       time_up,
    output logic       expired
);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

    state_t     state;
    logic [7:0] remaining;

    if ((START_TENS == 4'd0 && START_ONES == 4'd0) || START_TENS > 4'd9 ||
        START_ONES > 4'd9 || WARN_SEC < 0 || WARN_SEC > 99) begin : g_bad_param
        $error("shot_clock_timer: START must be BCD 01..99 and WARN_SEC 0..99");
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            tens    <= START_TENS;
            ones    <= START_ONES;
            time_up <= 1'b0;
        end else begin
            time_up <= 1'b0;
            if (stop) begin
                state <= IDLE;
                tens  <= START_TENS;
                ones  <= START_ONES;
            end else if (start_shot) begin
                state <= RUNNING;
                tens  <= START_TENS;
                ones  <= START_ONES;
            end else begin
                case (state)
                    RUNNING: begin
                        // A tick coinciding with pause entry is dropped.
                        if (pause) begin
                            state <= PAUSED;
                        end else if (one_sec) begin
                            if (tens == 4'd0 && ones <= 4'd1) begin
                                state   <= EXPIRED;
                                tens    <= 4'd0;
                                ones    <= 4'd0;
                                time_up <= 1'b1;
                            end else if (ones == 4'd0) begin
                                ones <= 4'd9;
                                tens <= tens - 4'd1;
                            end else begin
                                ones <= ones - 4'd1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) state <= RUNNING;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign remaining = 8'(tens) * 8'd10 + 8'(ones);

    assign running = (state == RUNNING);
    assign expired = (state == EXPIRED);
    assign warning = (state == RUNNING || state == PAUSED) && (remaining <= 8'(WARN_SEC));

endmodule
